// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite blitter: FSM state encoding, screen limits,
// default sprite geometry and the on-screen test used by the pixel clipper.
package sprite_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int DEF_SPR_W = 5;
  localparam int DEF_SPR_H = 5;
  localparam int DEF_PITCH = 5;
  localparam int DEF_COL_W = 3;
  localparam int CNT_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERASE = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Sums carry their overflow bit, so anything that wrapped is off-screen too.
  function automatic logic on_screen(input logic [8:0] sum_x, input logic [7:0] sum_y);
    return (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major 2-D pixel counter for the sprite blitter; the column is the inner
// loop, and last_o flags the bottom-right pixel of the sprite.
module sprite_scan_counter
  import sprite_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] row_o,
  output logic [CNT_W-1:0] col_o,
  output logic             last_o
);

  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             col_end_s;
  logic             row_end_s;

  assign col_end_s = (col_q == CNT_W'(SPR_W - 1));
  assign row_end_s = (row_q == CNT_W'(SPR_H - 1));
  assign last_o    = col_end_s && row_end_s;
  assign row_o     = row_q;
  assign col_o     = col_q;

  // Next-count logic: wrap the column, step the row, and fold back to 0 after the last pixel.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_end_s) begin
        col_d = '0;
        if (row_end_s) begin
          row_d = '0;
        end else begin
          row_d = row_q + CNT_W'(1);
        end
      end else begin
        col_d = col_q + CNT_W'(1);
        row_d = row_q;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: erases the previous sprite footprint, then draws a new shape
// at cell*PITCH, one pixel per cycle. Erase pass enabled by SPRITE_BLITTER_ERASE_EN.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPR_W       = DEF_SPR_W,
  parameter int SPR_H       = DEF_SPR_H,
  parameter int PITCH       = DEF_PITCH,
  parameter int COL_W       = DEF_COL_W,
  parameter bit TRANSPARENT = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             cell_x,
  input  logic [6:0]             cell_y,
  input  logic [SPR_W*SPR_H-1:0] shape,
  input  logic [COL_W-1:0]       colour,
  input  logic [COL_W-1:0]       bg_colour,
  output logic                   busy,
  output logic                   done,
  output logic                   plot,
  output logic [7:0]             x_out,
  output logic [6:0]             y_out,
  output logic [COL_W-1:0]       col_out
);

  localparam int NPIX = SPR_W * SPR_H;

  state_e            state_q, state_d;
  logic [7:0]        cx_q, cx_d;
  logic [6:0]        cy_q, cy_d;
  logic [NPIX-1:0]   shape_q, shape_d;
  logic [COL_W-1:0]  colour_q, colour_d;
  logic [COL_W-1:0]  bg_q, bg_d;
  logic [7:0]        ox_q, ox_d;
  logic [6:0]        oy_q, oy_d;
`ifdef SPRITE_BLITTER_ERASE_EN
  logic [7:0]        px_q, px_d;
  logic [6:0]        py_q, py_d;
`endif

  logic [CNT_W-1:0]  row_s, col_s;
  logic              last_s;
  logic              scan_erase_s;
  logic              scan_draw_s;
  logic [15:0]       prod_x_s, prod_y_s;
  logic [7:0]        base_x_s;
  logic [6:0]        base_y_s;
  logic [8:0]        sum_x_s;
  logic [7:0]        sum_y_s;
  logic [6:0]        lin_idx_s;
  logic [NPIX-1:0]   shifted_s;
  logic              shape_bit_s;
  logic              visible_s;

`ifdef SPRITE_BLITTER_ERASE_EN
  assign scan_erase_s = (state_q == ST_ERASE);
  assign base_x_s     = scan_erase_s ? px_q : ox_q;
  assign base_y_s     = scan_erase_s ? py_q : oy_q;
`else
  assign scan_erase_s = 1'b0;
  assign base_x_s     = ox_q;
  assign base_y_s     = oy_q;
`endif
  assign scan_draw_s = (state_q == ST_DRAW);

  // Origin arithmetic deliberately truncates to the 8/7-bit coordinate space.
  assign prod_x_s    = {8'd0, cx_q} * 16'(PITCH);
  assign prod_y_s    = {9'd0, cy_q} * 16'(PITCH);
  assign sum_x_s     = {1'b0, base_x_s} + {{(9 - CNT_W){1'b0}}, col_s};
  assign sum_y_s     = {1'b0, base_y_s} + {{(8 - CNT_W){1'b0}}, row_s};
  assign visible_s   = on_screen(sum_x_s, sum_y_s);
  assign lin_idx_s   = ({{(7 - CNT_W){1'b0}}, row_s} * 7'(SPR_W)) + {{(7 - CNT_W){1'b0}}, col_s};
  assign shifted_s   = shape_q << lin_idx_s;
  assign shape_bit_s = shifted_s[NPIX-1];

  sprite_scan_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_scan (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (!(scan_erase_s || scan_draw_s)),
    .en_i   (scan_erase_s || scan_draw_s),
    .row_o  (row_s),
    .col_o  (col_s),
    .last_o (last_s)
  );

  // FSM next state plus job latch, origin load and previous-origin update.
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    shape_d  = shape_q;
    colour_d = colour_q;
    bg_d     = bg_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
`ifdef SPRITE_BLITTER_ERASE_EN
    px_d     = px_q;
    py_d     = py_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cx_d     = cell_x;
          cy_d     = cell_y;
          shape_d  = shape;
          colour_d = colour;
          bg_d     = bg_colour;
`ifdef SPRITE_BLITTER_ERASE_EN
          state_d  = ST_ERASE;
`else
          state_d  = ST_LOAD;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERASE: begin
        if (last_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_ERASE;
        end
      end
      ST_LOAD: begin
        ox_d    = prod_x_s[7:0];
        oy_d    = prod_y_s[6:0];
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_DONE: begin
`ifdef SPRITE_BLITTER_ERASE_EN
        px_d    = ox_q;
        py_d    = oy_q;
`endif
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cx_q     <= 8'd0;
      cy_q     <= 7'd0;
      shape_q  <= '0;
      colour_q <= '0;
      bg_q     <= '0;
      ox_q     <= 8'd0;
      oy_q     <= 7'd0;
`ifdef SPRITE_BLITTER_ERASE_EN
      px_q     <= 8'd0;
      py_q     <= 7'd0;
`endif
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      shape_q  <= shape_d;
      colour_q <= colour_d;
      bg_q     <= bg_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
`ifdef SPRITE_BLITTER_ERASE_EN
      px_q     <= px_d;
      py_q     <= py_d;
`endif
    end
  end

  // Pixel outputs; held at zero while reset is asserted so nothing leaks mid-abort.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    plot    = 1'b0;
    x_out   = 8'd0;
    y_out   = 7'd0;
    col_out = '0;
    if (reset) begin
      busy = 1'b0;
    end else begin
      busy = (state_q != ST_IDLE);
      done = (state_q == ST_DONE);
      if (scan_erase_s) begin
        x_out   = sum_x_s[7:0];
        y_out   = sum_y_s[6:0];
        col_out = bg_q;
        plot    = visible_s;
      end else if (scan_draw_s) begin
        x_out = sum_x_s[7:0];
        y_out = sum_y_s[6:0];
        if (shape_bit_s) begin
          col_out = colour_q;
          plot    = visible_s;
        end else begin
          col_out = bg_q;
          plot    = visible_s && !TRANSPARENT;
        end
      end else begin
        plot = 1'b0;
      end
    end
  end

endmodule
